circuito_jogo_rodadas: RTL

Parametrised successor of the sequence-memory game top level. It plays progressive rounds against a stored sequence: round r requires the player to reproduce entries 0..r in order. A round is won only when every entry matches, and the next round adds one entry. A timeout aborts the game. Control (FSM) and datapath (round/play counters, play register, timeout timer, sequence ROM, comparator) live inside this block; 7-segment encoding of the debug outputs stays outside.

---
 rtl/circuito_jogo_rodadas_if.sv | 33 +++
 rtl/circuito_jogo_rodadas.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/circuito_jogo_rodadas_if.sv
// Player/debug bundle of the progressive-round sequence-memory game.
interface circuito_jogo_rodadas_if #(
  parameter int unsigned W = 4,
  parameter int unsigned A = 4
);
  logic         iniciar;
  logic [W-1:0] chaves;
  logic         acertou;
  logic         errou;
  logic         pronto;
  logic [W-1:0] leds;
  logic [A-1:0] db_rodada;
  logic [A-1:0] db_contagem;
  logic [W-1:0] db_memoria;
  logic [3:0]   db_estado;
  logic         db_igual;
  logic         db_tem_jogada;
  logic         db_timeout;

  // Player / board side
  modport master (
    output iniciar, chaves,
    input  acertou, errou, pronto, leds, db_rodada, db_contagem,
           db_memoria, db_estado, db_igual, db_tem_jogada, db_timeout
  );

  // Game engine side
  modport slave (
    input  iniciar, chaves,
    output acertou, errou, pronto, leds, db_rodada, db_contagem,
           db_memoria, db_estado, db_igual, db_tem_jogada, db_timeout
  );
endinterface

// File: rtl/circuito_jogo_rodadas.sv
// Sequence-memory game: round r asks the player to repeat ROM entries 0..r,
// with a per-play timeout. Control and datapath live together here.
module circuito_jogo_rodadas #(
  parameter int unsigned W       = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 3000,
  // Default image: entry a = 1 << (a mod W), built by repeating a flattened WxW identity.
  parameter logic [DEPTH*W-1:0] SEQ =
    (DEPTH*W)'({((DEPTH + W - 1) / W){(W*W)'({W{{W{1'b0}}, 1'b1}})}})
) (
  input  logic                    clock,
  input  logic                    reset,
  circuito_jogo_rodadas_if.slave  bus
);

  localparam int unsigned A  = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Enum values double as the debug state encoding.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } t_estado;

  t_estado       r_estado;
  logic [W-1:0]  r_prev;
  logic [W-1:0]  r_jogada;
  logic [A-1:0]  r_rodada;
  logic [A-1:0]  r_contagem;
  logic [TW-1:0] r_timer;
  logic          r_acertou;
  logic          r_errou;
  logic          r_pronto;
  logic          r_timeout;

  logic          w_jogada_feita;
  logic [W-1:0]  w_memoria;
  logic          w_igual;

  assign w_jogada_feita = (bus.chaves != '0) && (r_prev == '0);
  assign w_memoria      = SEQ[32'(r_contagem) * W +: W];
  assign w_igual        = (r_jogada == w_memoria);

  // Previous-cycle switches, for one-pulse-per-press detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= bus.chaves;
  end

  // Game FSM with counters, play register, timer and result flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_jogada   <= '0;
      r_rodada   <= '0;
      r_contagem <= '0;
      r_timer    <= '0;
      r_acertou  <= 1'b0;
      r_errou    <= 1'b0;
      r_pronto   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timer <= '0;
      case (r_estado)
        INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
          if (bus.iniciar) begin
            r_estado   <= PREPARACAO;
            r_jogada   <= '0;
            r_rodada   <= '0;
            r_contagem <= '0;
            r_acertou  <= 1'b0;
            r_errou    <= 1'b0;
            r_pronto   <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        PREPARACAO: begin
          r_jogada   <= '0;
          r_rodada   <= '0;
          r_contagem <= '0;
          r_estado   <= INICIA_RODADA;
        end
        INICIA_RODADA: begin
          r_contagem <= '0;
          r_estado   <= ESPERA;
        end
        ESPERA: begin
          r_timer <= (r_timer == TW'(TIMEOUT - 1)) ? r_timer : r_timer + TW'(1);
          if (w_jogada_feita) begin
            r_jogada <= bus.chaves;
            r_estado <= COMPARA;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_estado  <= FIM_TIMEOUT;
            r_errou   <= 1'b1;
            r_pronto  <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        COMPARA: begin
          if (!w_igual) begin
            r_estado <= FIM_ERRO;
            r_errou  <= 1'b1;
            r_pronto <= 1'b1;
          end else if (r_contagem < r_rodada) begin
            r_estado <= PROXIMA_JOGADA;
          end else if (r_rodada == A'(DEPTH - 1)) begin
            r_estado  <= FIM_ACERTO;
            r_acertou <= 1'b1;
            r_pronto  <= 1'b1;
          end else begin
            r_estado <= PROXIMA_RODADA;
          end
        end
        PROXIMA_JOGADA: begin
          r_contagem <= r_contagem + A'(1);
          r_estado   <= ESPERA;
        end
        PROXIMA_RODADA: begin
          r_rodada <= r_rodada + A'(1);
          r_estado <= INICIA_RODADA;
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  // Moore outputs, all decoded from registers
  assign bus.acertou       = r_acertou;
  assign bus.errou         = r_errou;
  assign bus.pronto        = r_pronto;
  assign bus.leds          = r_jogada;
  assign bus.db_rodada     = r_rodada;
  assign bus.db_contagem   = r_contagem;
  assign bus.db_memoria    = w_memoria;
  assign bus.db_estado     = r_estado;
  assign bus.db_igual      = w_igual;
  assign bus.db_tem_jogada = (r_prev != '0);
  assign bus.db_timeout    = r_timeout;

endmodule
